// File: rtl/cache_pkg.sv
// Types and defaults shared by the caches and the memory arbiter.
package cache_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_MWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick; on a tie the side not granted last wins.
module arb_rr2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  side_t      last,
  output logic       grant_valid,
  output side_t      grant_side
);

  // req[0] is the I side, req[1] the D side
  always_comb begin
    grant_valid = |req;
    grant_side  = SIDE_I;
    if (req == 2'b11)
      grant_side = (last == SIDE_I) ? SIDE_D : SIDE_I;
    else if (req[1])
      grant_side = SIDE_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I and D caches: round-robin grant,
// writeback-before-fill sequencing, fill data return and done pulse.
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int MWIDTH = DEF_MWIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_rden,
  input  logic [WIDTH-1:0]  i_rdaddress,
  input  logic              i_wren,
  input  logic [WIDTH-1:0]  i_wraddress,
  input  logic [MWIDTH-1:0] i_wdata,
  output logic [MWIDTH-1:0] i_q,
  output logic              i_done,
  output logic              i_busy,
  input  logic              d_rden,
  input  logic [WIDTH-1:0]  d_rdaddress,
  input  logic              d_wren,
  input  logic [WIDTH-1:0]  d_wraddress,
  input  logic [MWIDTH-1:0] d_wdata,
  output logic [MWIDTH-1:0] d_q,
  output logic              d_done,
  output logic              d_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [MWIDTH-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [MWIDTH-1:0] mem_rdata
);

  arb_state_t        state, state_nxt;
  side_t             side_r, last_r, grant_side;
  logic              grant_valid;
  logic              grant_wren;
  logic              rden_r;
  logic [WIDTH-1:0]  rdaddr_r, wraddr_r;
  logic [MWIDTH-1:0] wdata_r;

  arb_rr2 u_rr (
    .req         ({d_rden | d_wren, i_rden | i_wren}),
    .last        (last_r),
    .grant_valid (grant_valid),
    .grant_side  (grant_side)
  );

  assign grant_wren = (grant_side == SIDE_D) ? d_wren : i_wren;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = grant_wren ? WRITE : READ;
      WRITE:   if (mem_ack)     state_nxt = rden_r ? READ : DONE;
      READ:    if (mem_ack)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at grant so later requester activity cannot disturb the bus
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      side_r   <= SIDE_I;
      last_r   <= SIDE_I;
      rden_r   <= 1'b0;
      rdaddr_r <= '0;
      wraddr_r <= '0;
      wdata_r  <= '0;
      i_q      <= '0;
      d_q      <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          side_r <= grant_side;
          if (grant_side == SIDE_D) begin
            rden_r   <= d_rden;
            rdaddr_r <= d_rdaddress;
            wraddr_r <= d_wraddress;
            wdata_r  <= d_wdata;
          end else begin
            rden_r   <= i_rden;
            rdaddr_r <= i_rdaddress;
            wraddr_r <= i_wraddress;
            wdata_r  <= i_wdata;
          end
        end
        READ: if (mem_ack) begin
          if (side_r == SIDE_D) d_q <= mem_rdata;
          else                  i_q <= mem_rdata;
        end
        DONE: last_r <= side_r;
        default: ;
      endcase
    end
  end

  // Memory and status outputs decode only registered state and latched fields
  always_comb begin
    mem_req   = (state == WRITE) || (state == READ);
    mem_we    = (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WRITE) begin
      mem_addr  = wraddr_r;
      mem_wdata = wdata_r;
    end else if (state == READ) begin
      mem_addr  = rdaddr_r;
    end
    i_done = (state == DONE) && (side_r == SIDE_I);
    d_done = (state == DONE) && (side_r == SIDE_D);
    i_busy = (state != IDLE) && (side_r == SIDE_I);
    d_busy = (state != IDLE) && (side_r == SIDE_D);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory transactions and completions
// are queued when requests are driven and compared as the arbiter produces them.
module tb_mem_arbiter;

  typedef struct {
    bit          we;
    bit          side;
    bit          chain;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_t;

  typedef struct {
    bit          side;
    logic [31:0] q;
  } done_t;

  logic        clock, reset;
  logic        i_rden, i_wren, d_rden, d_wren;
  logic [31:0] i_rdaddress, i_wraddress, i_wdata, d_rdaddress, d_wraddress, d_wdata;
  logic [31:0] i_q, d_q;
  logic        i_done, i_busy, d_done, d_busy;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_ack_cyc = -10;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  bit          stray = 0;
  bit          tb_last = 0;
  logic [31:0] q_model [2];
  mem_t        mem_q [$];
  done_t       done_q [$];
  mem_t        cur;

  mem_arbiter #(.WIDTH(32), .MWIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_rden      (i_rden),
    .i_rdaddress (i_rdaddress),
    .i_wren      (i_wren),
    .i_wraddress (i_wraddress),
    .i_wdata     (i_wdata),
    .i_q         (i_q),
    .i_done      (i_done),
    .i_busy      (i_busy),
    .d_rden      (d_rden),
    .d_rdaddress (d_rdaddress),
    .d_wren      (d_wren),
    .d_wraddress (d_wraddress),
    .d_wdata     (d_wdata),
    .d_q         (d_q),
    .d_done      (d_done),
    .d_busy      (d_busy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: queues the bus traffic and completion one transaction implies
  task automatic expect_txn(input bit side, input bit rd, input logic [31:0] rdaddr,
                            input logic [31:0] rdata, input bit wr,
                            input logic [31:0] wraddr, input logic [31:0] wdata);
    mem_t  m;
    done_t d;
    if (wr) begin
      m.we = 1'b1; m.side = side; m.chain = 1'b0;
      m.addr = wraddr; m.wdata = wdata; m.rdata = '0;
      mem_q.push_back(m);
    end
    if (rd) begin
      m.we = 1'b0; m.side = side; m.chain = wr;
      m.addr = rdaddr; m.wdata = '0; m.rdata = rdata;
      mem_q.push_back(m);
      q_model[side] = rdata;
    end
    d.side = side;
    d.q    = q_model[side];
    done_q.push_back(d);
    tb_last = side;
  endtask

  // Wait for the requested sides to complete, dropping each request after its done
  task automatic serve(input bit want_i, input bit want_d, input int perturb_at);
    bit got_i, got_d;
    int n;
    got_i = !want_i;
    got_d = !want_d;
    n = 0;
    while (!(got_i && got_d) && n < 100) begin
      @(negedge clock);
      n++;
      if (perturb_at > 0 && n == perturb_at) i_rdaddress = 32'hBAD0_0000;
      if (i_done) begin got_i = 1'b1; i_rden = 1'b0; i_wren = 1'b0; end
      if (d_done) begin got_d = 1'b1; d_rden = 1'b0; d_wren = 1'b0; end
    end
    if (!(got_i && got_d)) check("serve_timeout", {got_i, got_d}, {want_i, want_d});
  endtask

  task automatic tie_read(input logic [31:0] ia, input logic [31:0] id,
                          input logic [31:0] da, input logic [31:0] dd);
    if (tb_last == 1'b0) begin
      expect_txn(1'b1, 1'b1, da, dd, 1'b0, '0, '0);
      expect_txn(1'b0, 1'b1, ia, id, 1'b0, '0, '0);
    end else begin
      expect_txn(1'b0, 1'b1, ia, id, 1'b0, '0, '0);
      expect_txn(1'b1, 1'b1, da, dd, 1'b0, '0, '0);
    end
    i_rden = 1'b1; i_rdaddress = ia;
    d_rden = 1'b1; d_rdaddress = da;
    serve(1'b1, 1'b1, 0);
  endtask

  // Memory model: checks each new request against the scoreboard and acks after mem_lat cycles
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (reset) begin
        wait_cnt = 0;
      end else if (stray && !mem_req) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        stray = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt == 0) begin
          if (mem_q.size() == 0) begin
            check("mem_unexpected", {mem_we, mem_addr}, 0);
            cur.we = mem_we; cur.addr = mem_addr; cur.rdata = '0; cur.side = d_busy;
            cur.chain = 1'b0; cur.wdata = mem_wdata;
          end else begin
            cur = mem_q.pop_front();
            check("mem_we", mem_we, cur.we);
            check("mem_addr", mem_addr, cur.addr);
            if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
            check("busy", {d_busy, i_busy}, cur.side ? 2'b10 : 2'b01);
            if (cur.chain) check("no_bubble", cyc, last_ack_cyc + 1);
          end
        end else begin
          check("hold_addr", mem_addr, cur.addr);
          check("hold_we", mem_we, cur.we);
        end
        if (wait_cnt >= mem_lat) begin
          mem_ack = 1'b1;
          mem_rdata = cur.rdata;
          last_ack_cyc = cyc;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Completion monitor
  initial begin
    done_t e;
    forever begin
      @(negedge clock);
      if (i_done || d_done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", {d_done, i_done}, 2'b00);
        end else begin
          e = done_q.pop_front();
          check("done_side", {d_done, i_done}, e.side ? 2'b10 : 2'b01);
          check("done_q", e.side ? d_q : i_q, e.q);
          check("done_lat", cyc, last_ack_cyc + 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    i_rden = 0; i_wren = 0; d_rden = 0; d_wren = 0;
    i_rdaddress = '0; i_wraddress = '0; i_wdata = '0;
    d_rdaddress = '0; d_wraddress = '0; d_wdata = '0;
    q_model[0] = '0; q_model[1] = '0;
    repeat (3) @(negedge clock);
    check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check("rst_side", {i_done, d_done, i_busy, d_busy}, 0);
    check("rst_q", {i_q, d_q}, 0);
    reset = 1'b0;

    // Two simultaneous pairs: D first, then I, twice
    mem_lat = 0;
    tie_read(32'h0000_1100, 32'h2222_0001, 32'h0000_3100, 32'h1111_0001);
    tie_read(32'h0000_1200, 32'h2222_0002, 32'h0000_3200, 32'h1111_0002);

    // I-only fill, memory acks one cycle after the request
    mem_lat = 1;
    expect_txn(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, '0, '0);
    i_rden = 1'b1; i_rdaddress = 32'h0000_1000;
    serve(1'b1, 1'b0, 0);

    // D writeback then fill, back-to-back on the bus
    mem_lat = 0;
    expect_txn(1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_0001, 1'b1, 32'h0000_2000, 32'h1234_5678);
    d_wren = 1'b1; d_wraddress = 32'h0000_2000; d_wdata = 32'h1234_5678;
    d_rden = 1'b1; d_rdaddress = 32'h0000_3000;
    serve(1'b0, 1'b1, 0);

    // D writeback only; d_q keeps its previous fill
    mem_lat = 2;
    expect_txn(1'b1, 1'b0, '0, '0, 1'b1, 32'h0000_5000, 32'h0BAD_F00D);
    d_wren = 1'b1; d_wraddress = 32'h0000_5000; d_wdata = 32'h0BAD_F00D;
    serve(1'b0, 1'b1, 0);

    // Slow read, requester changes its address mid-READ
    mem_lat = 5;
    expect_txn(1'b0, 1'b1, 32'h0000_4000, 32'h55AA_55AA, 1'b0, '0, '0);
    i_rden = 1'b1; i_rdaddress = 32'h0000_4000;
    serve(1'b1, 1'b0, 3);

    // Stray ack while idle
    stray = 1'b1;
    repeat (3) @(negedge clock);
    check("stray_idle", {mem_req, i_busy, d_busy, i_done, d_done}, 0);
    check("stray_q", {i_q, d_q}, {32'h55AA_55AA, 32'hCAFE_0001});

    // Reset during a writeback abandons the transaction
    begin
      mem_t m;
      m.we = 1'b1; m.side = 1'b1; m.chain = 1'b0;
      m.addr = 32'h0000_6000; m.wdata = 32'h7777_7777; m.rdata = '0;
      mem_q.push_back(m);
    end
    d_wren = 1'b1; d_wraddress = 32'h0000_6000; d_wdata = 32'h7777_7777;
    d_rden = 1'b1; d_rdaddress = 32'h0000_7000;
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin @(negedge clock); n++; end
    check("write_seen", mem_req && mem_we, 1'b1);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    d_wren = 1'b0; d_rden = 1'b0;
    #1;
    check("arst_mem", {mem_req, mem_we, mem_addr}, 0);
    check("arst_busy", {i_busy, d_busy}, 0);
    check("arst_q", {i_q, d_q}, 0);
    @(negedge clock);
    reset = 1'b0;
    tb_last = 1'b0;
    q_model[0] = '0; q_model[1] = '0;

    // After reset the D side wins the first tie again
    mem_lat = 1;
    tie_read(32'h0000_1300, 32'h2222_0003, 32'h0000_3300, 32'h1111_0003);

    repeat (3) @(negedge clock);
    check("mem_q_drained", mem_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that shares the single backing-memory port between the instruction cache and the data cache. Each cache presents its miss traffic: an optional dirty-block writeback followed by an optional block fill. The arbiter grants one cache at a time with round-robin fairness and sequences writeback-before-fill against a ready/ack memory handshake. It returns fill data and a one-cycle completion pulse to the granted cache.

## Interface
- WIDTH, 32, address width (byte address as produced by the caches)
- MWIDTH, 32, memory/block data width
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- i_rden / d_rden  in  1  requester wants a block fill (level, held until its done)
- i_rdaddress / d_rdaddress  in  WIDTH  fill address
- i_wren / d_wren  in  1  requester has a dirty writeback (level, held until its done)
- i_wraddress / d_wraddress  in  WIDTH  writeback address
- i_wdata / d_wdata  in  MWIDTH  writeback data
- i_q / d_q  out  MWIDTH  fill data, valid when matching done=1, holds until next fill for that side
- i_done / d_done  out  1  one-cycle pulse: requester's whole transaction finished
- i_busy / d_busy  out  1  1 while that requester's transaction is granted and in flight
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  MWIDTH  write data
- mem_ack  in  1  one-cycle pulse, memory completed current request
- mem_rdata  in  MWIDTH  read data, valid with mem_ack on a read

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: a requester is pending if rden|wren. If exactly one is pending, grant it. If both are pending, grant the side not granted last (the pointer `last`). After reset `last`=I, so D wins the first tie. On grant, latch side, rden, wren, addresses and wdata into internal registers. Go to WRITE if wren, else READ.
- WRITE: mem_req=1, mem_we=1, mem_addr=latched wraddress, mem_wdata=latched wdata. On mem_ack, go to READ if latched rden, else DONE.
- READ: mem_req=1, mem_we=0, mem_addr=latched rdaddress. On mem_ack, capture mem_rdata into granted side's q and go to DONE.
- DONE: granted side's done=1 for this cycle, update `last`=granted side, go to IDLE.
- busy for the granted side is 1 in WRITE, READ and DONE; the other side's busy stays 0.
- All memory-side outputs are decoded from registered state and latched fields; no combinational path from requester inputs to mem_*.
- Boundary behaviour:
  - mem_ack in IDLE or DONE is ignored.
  - Requester inputs changing or dropping mid-transaction are ignored, since fields are latched. The transaction still completes and done still pulses.
  - The requester must drop rden/wren in the cycle after done; if it is still high it is treated as a new request.
  - Addresses pass through unmodified; no width conversion.

## Timing
- Reset values: state=IDLE, last=I, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_q=d_q=0, i_done=d_done=0, i_busy=d_busy=0.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously) and the transaction is abandoned. The memory must tolerate a dropped mem_req.
- Request visible before edge N: mem_req=1 from edge N.
- Read-only, mem_ack at earliest in cycle N: q updated and done=1 after edge N+1. Minimum fill latency is 2 cycles; each extra memory wait cycle adds 1.
- Writeback+fill: WRITE ack at edge N+1 puts READ on the bus from edge N+1, with no idle bubble. Done appears one cycle after the read ack.
- Back-to-back: after DONE, the earliest next grant is the following IDLE edge. Throughput ceiling is one transaction per 3+memory-latency cycles.

## Structure
- Shared package cache_pkg: state enum (IDLE/WRITE/READ/DONE), side encoding (SIDE_I=0, SIDE_D=1), default WIDTH/MWIDTH constants, shared with i_cache/d_cache.
- One sub-module, arb_rr2: pure combinational 2-way round-robin pick. Inputs req[1:0] and last; outputs grant_valid and grant_side. It is unit-testable on its own.
- Top-level mem_arbiter holds the FSM, latched fields and the output registers.

## Test plan
- I-only read 0x0000_1000, memory acks 1 cycle after req with rdata 0xDEADBEEF -> mem_we=0, mem_addr=0x1000, i_q=0xDEADBEEF, i_done pulses once, d_busy stays 0.
- D writeback 0x2000/0x12345678 plus fill 0x3000 -> write at 0x2000 with wdata 0x12345678, then read at 0x3000 with no idle cycle between; d_done pulses once, after the read ack only.
- Both request fills simultaneously from reset -> D served first, then I; a second simultaneous pair -> D, then I again. Alternation holds because `last` updates each grant.
- Memory holds ack low 5 cycles on a read -> mem_req, mem_addr stable throughout; done exactly one cycle after ack; stray ack injected in IDLE causes no output change.
- Requester changes rdaddress mid-READ -> mem_addr keeps the latched value.
- Reset asserted during WRITE -> mem_req=0 and busy=0 the same cycle; after release, a new request is served normally with D-priority tie-break.
